spi_slave_frame_rx: RTL and testbench

//  SPI slave receiver (mode 0, MSB first) that is the target end of the host-side SPI link feeding the CNN core.

---
 rtl/spi_slave_frame_rx_if.sv | 37 +++
 rtl/spi_slave_frame_rx.sv | 177 +++++++++++++++++
 tb/tb_spi_slave_frame_rx.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_frame_rx_if
// Brief    : SPI pins, the byte valid/ready handshake and the status flags of
//            the frame receiver, grouped as one bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_frame_rx_if #(
    parameter int IDX_W = 10
);
    logic             spi_sclk;
    logic             spi_ss;
    logic             spi_mosi;
    logic             spi_miso;
    logic [7:0]       rx_data;
    logic [IDX_W-1:0] rx_idx;
    logic             rx_valid;
    logic             rx_ready;
    logic             frame_done;
    logic             frame_abort;
    logic             overflow;
    logic             overflow_clr;
    logic             busy;

    modport slave (
        input  spi_sclk, spi_ss, spi_mosi, rx_ready, overflow_clr,
        output spi_miso, rx_data, rx_idx, rx_valid, frame_done, frame_abort,
               overflow, busy
    );

    modport master (
        output spi_sclk, spi_ss, spi_mosi, rx_ready, overflow_clr,
        input  spi_miso, rx_data, rx_idx, rx_valid, frame_done, frame_abort,
               overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_frame_rx
// Brief    : Mode-0 SPI slave that oversamples the link, assembles bytes tagged
//            with their frame position and echoes received bytes on MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_frame_rx #(
    parameter int         FRAME_BYTES = 1024,
    parameter logic [7:0] TX_ID       = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    spi_slave_frame_rx_if.slave  bus
);
    localparam int               IDX_W    = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;

    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       tx_q;
    logic [IDX_W-1:0] byte_cnt_q;
    logic [7:0]       rx_data_q;
    logic [IDX_W-1:0] rx_idx_q;
    logic             rx_valid_q;
    logic             frame_done_q;
    logic             frame_abort_q;
    logic             overflow_q;

    logic             w_sclk_s;
    logic             w_ss_s;
    logic             w_mosi_s;
    logic             w_in_recv;
    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_ss_fall;
    logic             w_ss_rise;
    logic             w_byte_done;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;
    logic [IDX_W-1:0] w_byte_cnt_adv;

    // SS synchronizer resets to the deselected level so release never fakes a select edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_prev_q <= w_sclk_s;
            ss_prev_q   <= w_ss_s;
        end
    end

    assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign w_ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign w_in_recv   = (state_q == RECV);
    assign w_sclk_rise = w_in_recv & ~w_ss_s & w_sclk_s & ~sclk_prev_q;
    assign w_sclk_fall = w_in_recv & ~w_ss_s & ~w_sclk_s & sclk_prev_q;
    assign w_ss_fall   = ss_prev_q & ~w_ss_s;
    assign w_ss_rise   = ~ss_prev_q & w_ss_s;

    assign w_byte_done    = w_in_recv & (bit_cnt_q == 4'd8);
    assign w_accept       = rx_valid_q & bus.rx_ready;
    assign w_load         = w_byte_done & (~rx_valid_q | w_accept);
    assign w_drop         = w_byte_done & ~w_load;
    assign w_byte_cnt_adv = w_byte_done ? byte_cnt_q + IDX_W'(1) : byte_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_ss_fall) state_d = RECV;
            RECV:    if (w_ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'd0;
            tx_q          <= TX_ID;
            byte_cnt_q    <= '0;
            rx_data_q     <= 8'd0;
            rx_idx_q      <= '0;
            rx_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;

            if ((state_q == IDLE) && w_ss_fall) begin
                bit_cnt_q <= 4'd0;
                tx_q      <= TX_ID;
            end

            if (w_sclk_rise) begin
                shift_q   <= {shift_q[6:0], w_mosi_s};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end

            // The fall closing a byte must not shift: bit 7 of the reload is already on MISO
            if (w_sclk_fall && (bit_cnt_q != 4'd0)) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end

            if (w_byte_done) begin
                bit_cnt_q    <= 4'd0;
                tx_q         <= shift_q;
                byte_cnt_q   <= w_byte_cnt_adv;
                frame_done_q <= (byte_cnt_q == LAST_IDX);
            end

            if (w_load) begin
                rx_data_q  <= shift_q;
                rx_idx_q   <= byte_cnt_q;
                rx_valid_q <= 1'b1;
            end else if (w_accept) begin
                rx_valid_q <= 1'b0;
            end

            if (bus.overflow_clr) begin
                overflow_q <= 1'b0;
            end else if (w_drop) begin
                overflow_q <= 1'b1;
            end

            if (w_in_recv && w_ss_rise) begin
                bit_cnt_q     <= 4'd0;
                byte_cnt_q    <= '0;
                frame_abort_q <= (w_byte_cnt_adv != '0);
            end
        end
    end

    assign bus.spi_miso    = w_in_recv & ~w_ss_s & tx_q[7];
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_idx      = rx_idx_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = w_in_recv;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_frame_rx
// Brief    : Bench for spi_slave_frame_rx: a transaction-level host model plus a
//            per-cycle monitor of the byte handshake, flags and MISO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_frame_rx;
    localparam int         FB    = 1024;
    localparam int         IDX_W = 10;
    localparam logic [7:0] TX_ID = 8'hA5;

    logic clk;
    logic rst;
    int   ready_mode;

    spi_slave_frame_rx_if #(.IDX_W(IDX_W)) bus ();

    spi_slave_frame_rx #(
        .FRAME_BYTES (FB),
        .TX_ID       (TX_ID),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Host-side model: byte position in frame, position in transaction, last byte sent
    logic [IDX_W+7:0] exp_q[$];
    logic [IDX_W+7:0] got_q[$];
    int               mcnt      = 0;
    int               tpos      = 0;
    logic [7:0]       last_rx   = 8'h00;
    int               exp_done  = 0;
    int               exp_abort = 0;
    int               got_done  = 0;
    int               got_abort = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.rx_ready = 1'b0;
                1:       bus.rx_ready = 1'b1;
                default: bus.rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle monitor
    logic             prev_hold = 1'b0;
    logic [7:0]       prev_data;
    logic [IDX_W-1:0] prev_idx;
    logic             last_ss   = 1'b1;
    int               ss_stable = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            ss_stable = 0;
        end else begin
            if (prev_hold) begin
                chk_eq("hold_valid", 32'(bus.rx_valid), 32'd1);
                chk_eq("hold_data", 32'(bus.rx_data), 32'(prev_data));
                chk_eq("hold_idx", 32'(bus.rx_idx), 32'(prev_idx));
            end
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_byte", {14'd0, bus.rx_idx, bus.rx_data}, 32'hFFFFFFFF);
                end else begin
                    logic [IDX_W+7:0] e;
                    e = exp_q.pop_front();
                    chk_eq("rx_data", 32'(bus.rx_data), 32'(e[7:0]));
                    chk_eq("rx_idx", 32'(bus.rx_idx), 32'(e[IDX_W+7:8]));
                    got_q.push_back({bus.rx_idx, bus.rx_data});
                end
            end
            prev_hold = bus.rx_valid && !bus.rx_ready;
            prev_data = bus.rx_data;
            prev_idx  = bus.rx_idx;
            if (bus.frame_done) begin
                got_done++;
                chk_eq("done_with_last", {31'd0, bus.rx_valid && (bus.rx_idx == IDX_W'(FB - 1))}, 32'd1);
            end
            if (bus.frame_abort) got_abort++;
            if (bus.spi_ss == last_ss) ss_stable++;
            else ss_stable = 0;
            last_ss = bus.spi_ss;
            if (ss_stable >= 6) begin
                chk_eq("busy", 32'(bus.busy), 32'(!bus.spi_ss));
                if (bus.spi_ss) chk_eq("miso_idle", 32'(bus.spi_miso), 32'd0);
            end
        end
    end

    task automatic ss_low();
        bus.spi_ss = 1'b0;
        tpos = 0;
        tick(2);
    endtask

    task automatic ss_high();
        tick(2);
        bus.spi_ss = 1'b1;
        if (mcnt != 0) exp_abort++;
        mcnt = 0;
        tick(8);
    endtask

    // Sends the top n bits of b; a full byte is recorded in the model on its 8th rise
    task automatic send_bits(input logic [7:0] b, input int n, input bit drop, output logic [7:0] cap);
        logic [7:0] em;
        logic [7:0] mask;
        em  = (tpos == 0) ? TX_ID : last_rx;
        cap = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.spi_mosi = b[7-i];
            tick(4);
            cap[7-i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            if (i == 7) begin
                if (!drop) exp_q.push_back({IDX_W'(mcnt), b});
                if (mcnt == FB - 1) exp_done++;
                mcnt    = (mcnt + 1) % FB;
                tpos    = tpos + 1;
                last_rx = b;
            end
            tick(4);
            bus.spi_sclk = 1'b0;
        end
        mask = 8'(8'hFF << (8 - n));
        chk_eq("miso_byte", 32'(cap & mask), 32'(em & mask));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        chk_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        #2;
    endtask

    initial begin
        logic [7:0] cap;
        logic [7:0] cap0;
        int         g0;
        int         d0;
        int         a0;

        bus.spi_sclk     = 1'b0;
        bus.spi_ss       = 1'b1;
        bus.spi_mosi     = 1'b0;
        bus.overflow_clr = 1'b0;
        ready_mode       = 2;
        rst              = 1'b1;

        // Reset with inputs toggling
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            bus.spi_sclk     = 1'($urandom_range(0, 1));
            bus.spi_ss       = 1'($urandom_range(0, 1));
            bus.spi_mosi     = 1'($urandom_range(0, 1));
            bus.overflow_clr = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_eq("reset_outputs",
                   {14'd0, bus.spi_miso, bus.rx_valid, bus.rx_data, bus.rx_idx,
                    bus.frame_done, bus.frame_abort, bus.overflow, bus.busy}, 32'd0);
        end
        @(posedge clk);
        #2;
        bus.spi_sclk     = 1'b0;
        bus.spi_ss       = 1'b1;
        bus.spi_mosi     = 1'b0;
        bus.overflow_clr = 1'b0;
        ready_mode       = 1;
        tick(1);
        rst = 1'b0;
        tick(6);
        @(negedge clk);
        chk_eq("post_reset_busy", 32'(bus.busy), 32'd0);
        chk_eq("post_reset_miso", 32'(bus.spi_miso), 32'd0);
        tick(1);

        // Ten bytes then SS high mid-frame
        g0 = got_q.size();
        a0 = got_abort;
        ss_low();
        for (int i = 0; i < 10; i++) send_bits(8'(8'hAA + i), 8, 1'b0, cap);
        drain();
        ss_high();
        chk_eq("t2_count", 32'(got_q.size() - g0), 32'd10);
        chk_eq("t2_first", 32'(got_q[g0]), 32'({10'd0, 8'hAA}));
        chk_eq("t2_last", 32'(got_q[g0+9]), 32'({10'd9, 8'hB3}));
        chk_eq("t2_abort", 32'(got_abort - a0), 32'd1);

        // Full frame plus one byte
        d0 = got_done;
        ss_low();
        for (int i = 0; i < FB; i++) send_bits(8'(i), 8, 1'b0, cap);
        drain();
        chk_eq("t3_done", 32'(got_done - d0), 32'd1);
        chk_eq("t3_last", 32'(got_q[$]), 32'({10'd1023, 8'hFF}));
        send_bits(8'h42, 8, 1'b0, cap);
        drain();
        chk_eq("t3_wrap", 32'(got_q[$]), 32'({10'd0, 8'h42}));
        ss_high();
        ss_low();
        a0 = got_abort;
        for (int i = 0; i < FB; i++) send_bits(8'($urandom), 8, 1'b0, cap);
        drain();
        ss_high();
        chk_eq("t3_no_abort", 32'(got_abort - a0), 32'd0);

        // Overflow
        ready_mode = 0;
        ss_low();
        send_bits(8'h11, 8, 1'b0, cap);
        send_bits(8'h22, 8, 1'b1, cap);
        tick(4);
        @(negedge clk);
        chk_eq("t4_data", 32'(bus.rx_data), 32'h11);
        chk_eq("t4_valid", 32'(bus.rx_valid), 32'd1);
        chk_eq("t4_ovf", 32'(bus.overflow), 32'd1);
        @(posedge clk);
        #2;
        bus.overflow_clr = 1'b1;
        tick(1);
        bus.overflow_clr = 1'b0;
        @(negedge clk);
        chk_eq("t4_ovf_clr", 32'(bus.overflow), 32'd0);
        ready_mode = 1;
        drain();
        send_bits(8'h33, 8, 1'b0, cap);
        drain();
        chk_eq("t4_idx2", 32'(got_q[$]), 32'({10'd2, 8'h33}));
        ss_high();

        // Fragments
        a0 = got_abort;
        ss_low();
        send_bits(8'hF0, 4, 1'b0, cap);
        ss_high();
        chk_eq("t5_frag_no_abort", 32'(got_abort - a0), 32'd0);
        ss_low();
        send_bits(8'h3C, 8, 1'b0, cap);
        drain();
        chk_eq("t5_3c", 32'(got_q[$]), 32'({10'd0, 8'h3C}));
        send_bits(8'h96, 4, 1'b0, cap);
        ss_high();
        chk_eq("t5_abort", 32'(got_abort - a0), 32'd1);

        // MISO echo
        ss_low();
        send_bits(8'h5A, 8, 1'b0, cap0);
        send_bits(8'hC3, 8, 1'b0, cap);
        chk_eq("t6_id", 32'(cap0), 32'hA5);
        chk_eq("t6_echo", 32'(cap), 32'h5A);
        drain();
        ss_high();

        // Reset mid-transaction: frame lost silently, fresh frame after release
        a0 = got_abort;
        ss_low();
        for (int i = 0; i < 3; i++) send_bits(8'($urandom), 8, 1'b0, cap);
        drain();
        rst = 1'b1;
        tick(3);
        rst  = 1'b0;
        mcnt = 0;
        tpos = 0;
        tick(4);
        chk_eq("rst_no_abort", 32'(got_abort - a0), 32'd0);
        send_bits(8'h99, 8, 1'b0, cap);
        drain();
        chk_eq("rst_idx0", 32'(got_q[$]), 32'({10'd0, 8'h99}));
        ss_high();

        // Randomized transactions with a random-ready sink
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            int nb;
            nb = $urandom_range(1, 12);
            ss_low();
            for (int i = 0; i < nb; i++) send_bits(8'($urandom), 8, 1'b0, cap);
            if ($urandom_range(0, 2) == 0) send_bits(8'($urandom), $urandom_range(1, 7), 1'b0, cap);
            drain();
            ss_high();
        end
        @(negedge clk);
        chk_eq("final_ovf", 32'(bus.overflow), 32'd0);

        tick(10);
        chk_eq("done_total", 32'(got_done), 32'(exp_done));
        chk_eq("abort_total", 32'(got_abort), 32'(exp_abort));
        chk_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
